// File: rtl/cpu_bus_pkg.sv
// ----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types and constants for the CPU-to-Wishbone bus master.
//   bus_state_t      : master FSM states (IDLE, BUS, DONE)
//   BUS_ERR_NONE     : access completed normally
//   BUS_ERR_BUS      : slave signalled wb_err_i
//   BUS_ERR_TIMEOUT  : watchdog expired (only with BUS_TIMEOUT_EN)
// ----------------------------------------------------------------------------
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    localparam logic [1:0] BUS_ERR_NONE    = 2'b00;
    localparam logic [1:0] BUS_ERR_BUS     = 2'b01;
    localparam logic [1:0] BUS_ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/cpu_bus_master_if.sv
// ----------------------------------------------------------------------------
// cpu_bus_master_if
// Bundles the CPU-side request/response signals and the Wishbone master
// signals of cpu_bus_master.
//   Parameters : DATA_W (multiple of 8), ADDR_W
//   modport master : the bus master itself (drives cpu_rdata/ready/err and
//                    the wb_*_o signals, receives cpu request and wb_*_i)
//   modport slave  : the environment (CPU core + Wishbone slave side)
// ----------------------------------------------------------------------------
interface cpu_bus_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [SEL_W-1:0]  cpu_be;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;
    logic [1:0]        cpu_err_code;

    // Wishbone side
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [SEL_W-1:0]  wb_sel_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_rdata, cpu_ready, cpu_err, cpu_err_code,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_rdata, cpu_ready, cpu_err, cpu_err_code,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/cpu_bus_master_timeout_cnt.sv
// ----------------------------------------------------------------------------
// bus_timeout_cnt
// Saturating wait-cycle counter used as the bus watchdog.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   clr   : force the count to zero (has priority over en)
//   en    : count one wait cycle; the count saturates at all-ones
//   hit   : count equals LIMIT
// ----------------------------------------------------------------------------
module bus_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int          CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/cpu_bus_master.sv
// ----------------------------------------------------------------------------
// cpu_bus_master
// Bus-interface unit between the multi-cycle CPU core and a Wishbone bus.
// Accepts one CPU request at a time, runs a single classic Wishbone cycle,
// and returns registered read data with a one-cycle cpu_ready pulse. Failed
// accesses raise cpu_err with cpu_err_code (01 bus error, 10 timeout), and
// the code is held until the next completion.
//
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : cpu_bus_master_if.master (CPU request/response + Wishbone master)
// Parameters:
//   DATA_W (multiple of 8), ADDR_W, TIMEOUT_CYC (1..65535)
// Configuration macro:
//   BUS_TIMEOUT_EN : when defined, a watchdog aborts the Wishbone cycle after
//                    TIMEOUT_CYC wait cycles with code 10. When undefined the
//                    master waits indefinitely for ack or err.
// ----------------------------------------------------------------------------
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    cpu_bus_master_if.master    bus
);
    localparam int SEL_W = DATA_W / 8;

    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("cpu_bus_master: DATA_W must be a multiple of 8");
    end
    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_bad_timeout
        $error("cpu_bus_master: TIMEOUT_CYC must be in 1..65535");
    end

    bus_state_t        state_q,        state_d;
    logic [DATA_W-1:0] cpu_rdata_q,    cpu_rdata_d;
    logic              cpu_ready_q,    cpu_ready_d;
    logic              cpu_err_q,      cpu_err_d;
    logic [1:0]        cpu_err_code_q, cpu_err_code_d;
    logic              wb_cyc_q,       wb_cyc_d;
    logic              wb_we_q,        wb_we_d;
    logic [ADDR_W-1:0] wb_adr_q,       wb_adr_d;
    logic [SEL_W-1:0]  wb_sel_q,       wb_sel_d;
    logic [DATA_W-1:0] wb_dat_q,       wb_dat_d;

    logic              timeout_hit;

`ifdef BUS_TIMEOUT_EN
    logic cnt_en;

    // Count only the cycles that neither acknowledge nor fail; the counter
    // sits at zero whenever no Wishbone cycle is in progress.
    assign cnt_en = (state_q == BUS) && !bus.wb_ack_i && !bus.wb_err_i;

    bus_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != BUS),
        .en    (cnt_en),
        .hit   (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_ready_d    = 1'b0;
        cpu_err_d      = 1'b0;
        cpu_err_code_d = cpu_err_code_q;
        wb_cyc_d       = wb_cyc_q;
        wb_we_d        = wb_we_q;
        wb_adr_d       = wb_adr_q;
        wb_sel_d       = wb_sel_q;
        wb_dat_d       = wb_dat_q;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    // The Wishbone output registers double as the request
                    // capture registers, so the bus sees a stable request.
                    state_d  = BUS;
                    wb_cyc_d = 1'b1;
                    wb_we_d  = bus.cpu_we;
                    wb_adr_d = bus.cpu_addr;
                    wb_sel_d = bus.cpu_be;
                    wb_dat_d = bus.cpu_wdata;
                end
            end

            BUS: begin
                // Error outranks ack, and a response on the final wait cycle
                // outranks the watchdog.
                if (bus.wb_err_i) begin
                    state_d        = DONE;
                    wb_cyc_d       = 1'b0;
                    wb_we_d        = 1'b0;
                    cpu_ready_d    = 1'b1;
                    cpu_err_d      = 1'b1;
                    cpu_err_code_d = BUS_ERR_BUS;
                    cpu_rdata_d    = '0;
                end else if (bus.wb_ack_i) begin
                    state_d        = DONE;
                    wb_cyc_d       = 1'b0;
                    wb_we_d        = 1'b0;
                    cpu_ready_d    = 1'b1;
                    cpu_err_code_d = BUS_ERR_NONE;
                    if (!wb_we_q) begin
                        cpu_rdata_d = bus.wb_dat_i;
                    end
                end else if (timeout_hit) begin
                    state_d        = DONE;
                    wb_cyc_d       = 1'b0;
                    wb_we_d        = 1'b0;
                    cpu_ready_d    = 1'b1;
                    cpu_err_d      = 1'b1;
                    cpu_err_code_d = BUS_ERR_TIMEOUT;
                    cpu_rdata_d    = '0;
                end
            end

            DONE: begin
                // cpu_req is deliberately ignored here: a held request is
                // only picked up again once back in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                wb_cyc_d = 1'b0;
                wb_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cpu_rdata_q    <= '0;
            cpu_ready_q    <= 1'b0;
            cpu_err_q      <= 1'b0;
            cpu_err_code_q <= BUS_ERR_NONE;
            wb_cyc_q       <= 1'b0;
            wb_we_q        <= 1'b0;
            wb_adr_q       <= '0;
            wb_sel_q       <= '0;
            wb_dat_q       <= '0;
        end else begin
            state_q        <= state_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_ready_q    <= cpu_ready_d;
            cpu_err_q      <= cpu_err_d;
            cpu_err_code_q <= cpu_err_code_d;
            wb_cyc_q       <= wb_cyc_d;
            wb_we_q        <= wb_we_d;
            wb_adr_q       <= wb_adr_d;
            wb_sel_q       <= wb_sel_d;
            wb_dat_q       <= wb_dat_d;
        end
    end

    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.cpu_ready    = cpu_ready_q;
    assign bus.cpu_err      = cpu_err_q;
    assign bus.cpu_err_code = cpu_err_code_q;
    // Single-transfer cycles only, so strobe and cycle are the same flop.
    assign bus.wb_cyc_o     = wb_cyc_q;
    assign bus.wb_stb_o     = wb_cyc_q;
    assign bus.wb_we_o      = wb_we_q;
    assign bus.wb_adr_o     = wb_adr_q;
    assign bus.wb_sel_o     = wb_sel_q;
    assign bus.wb_dat_o     = wb_dat_q;

endmodule

// File: doc/cpu_bus_master.md
# cpu_bus_master

Parametrised bus-interface unit between the multi-cycle CPU core and the Wishbone system bus. It replaces the raw `MIO_ready` / `cpu_stb_o` handshake: it registers one CPU memory request at a time, drives a classic single-transfer Wishbone cycle, and returns read data plus a completion pulse. It adds byte selects, bus-error reporting and an optional watchdog timeout. The error codes it produces feed the CPU's interrupt-cause logic.

## Interface
- `DATA_W`, default 32: data width; must be a multiple of 8.
- `ADDR_W`, default 32: address width.
- `TIMEOUT_CYC`, default 255: number of wait cycles before abort; valid range 1..65535. Used only with `BUS_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; sampled in IDLE only.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  byte address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_be`  in  DATA_W/8  byte enables.
- `cpu_rdata`  out  DATA_W  registered read data; valid while `cpu_ready` is high.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  qualifies `cpu_ready`: the access failed.
- `cpu_err_code`  out  2  00 none, 01 bus error, 10 timeout; held until the next completion.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone control signals.
- `wb_adr_o`  out  ADDR_W  Wishbone address; `wb_sel_o`  out  DATA_W/8  byte selects; `wb_dat_o`  out  DATA_W  write data.
- `wb_dat_i`  in  DATA_W;  `wb_ack_i`, `wb_err_i`  in  1  slave responses.

## Operation
- FSM states: IDLE, BUS, DONE. Reset, or any cycle with `reset`=0, forces IDLE.
- IDLE: when `cpu_req`=1, capture `cpu_we`, `cpu_addr`, `cpu_wdata` and `cpu_be` into registers, clear the wait counter, and go to BUS.
- BUS: `wb_cyc_o`=`wb_stb_o`=1; the Wishbone outputs come from the captured registers. Exit priority on a given cycle:
  1. `wb_err_i` → go to DONE, code 01.
  2. `wb_ack_i` → go to DONE, code 00; `cpu_rdata` ← `wb_dat_i` on a read, unchanged on a write.
  3. Counter equal to `TIMEOUT_CYC` → go to DONE, code 10.
  4. Otherwise stay in BUS and increment the counter.
- DONE: lasts exactly one cycle with `cpu_ready`=1 and `cpu_err`=(code≠00), then go to IDLE. `cpu_req` is ignored in DONE.
- When `cpu_err`=1, `cpu_rdata` = 0.
- Requests arriving in BUS or DONE are not queued. The CPU holds `cpu_req` until it sees `cpu_ready`.
- Counter width is clog2(TIMEOUT_CYC+1). The counter saturates and never wraps.
- Reset values: all outputs 0 (`cpu_rdata`, `wb_adr_o`, `wb_dat_o`, `wb_sel_o` included), state IDLE, counter 0.
- Reset mid-BUS: the cycle is dropped (`wb_cyc_o`=0 on the next cycle) and no `cpu_ready` is issued.

## Timing
- Request at cycle N (IDLE) → `wb_cyc_o`/`wb_stb_o` high from N+1.
- Ack at cycle M → Wishbone control low and `cpu_ready` high at M+1 → IDLE at M+2.
- Zero-wait slave (ack at N+1): `cpu_ready` at N+2. Throughput is one access per 3 cycles.
- Timeout: with no response, `cpu_ready`/`cpu_err` rise at N+2+TIMEOUT_CYC.
- All outputs are registered; there is no combinational path from the `wb_*_i` inputs to the `cpu_*` outputs.

## Configuration
- `BUS_TIMEOUT_EN` defined: watchdog counter present, code 10 reachable.
- `BUS_TIMEOUT_EN` not defined: no counter logic; the BUS state waits indefinitely for ack or err, and code 10 is never produced. `TIMEOUT_CYC` is ignored.

## Structure
- Package `cpu_bus_pkg` holds:
  - state enum `bus_state_t` {IDLE, BUS, DONE};
  - error-code localparams `BUS_ERR_NONE`, `BUS_ERR_BUS`, `BUS_ERR_TIMEOUT`.
- One sub-module, `bus_timeout_cnt`: saturating counter with clear/enable inputs and a `hit` output, instantiated only under `BUS_TIMEOUT_EN`.

## Test plan
- Zero-wait read: request at addr 0x0000_0010, slave acks at N+1 with 0xDEAD_BEEF → `cpu_ready` at N+2, `cpu_rdata`=0xDEAD_BEEF, `cpu_err`=0.
- Write with `cpu_be`=4'b0011, data 0x1234_5678, 3 wait states → `wb_sel_o`=0011 and `wb_we_o`=1 throughout the cycle; `cpu_ready` at N+5.
- Slave asserts `wb_err_i` and `wb_ack_i` together → `cpu_err`=1, `cpu_err_code`=01, `cpu_rdata`=0.
- `BUS_TIMEOUT_EN`, `TIMEOUT_CYC`=4, silent slave → `cpu_ready`/`cpu_err` at N+6, code 10, `wb_cyc_o` low at N+6.
- `reset` driven low two cycles into BUS → `wb_cyc_o`=0 on the next edge, no `cpu_ready`, outputs at reset values; a new request afterwards completes normally.
- `cpu_req` held high across DONE → exactly one access per request, and the next access starts only from IDLE.
